fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage for the 5-stage MIPS pipeline.
- Owns the PC and issues word fetches to the I-cache, waiting on Ihit across misses.
- Predecodes branches and holds one fetched instruction in an output buffer.
- Produces PC/instr/PCPlus4/Branch that the IF/ID decode register samples; honours the same advance condition (en & Dhit) and accepts redirects from branch resolution.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset (bits [1:0] must be 0).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  downstream decode register enable (not stalled).
- Dhit  input  1  D-cache hit; downstream advances only when en & Dhit.
- redirect  input  1  branch/jump resolved taken or mispredicted; flush and refetch.
- redirectPC  input  32  new fetch address; bits [1:0] ignored, forced 0.
- icacheReq  output  1  fetch request valid.
- icacheAddr  output  32  fetch word address.
- icacheInstr  input  32  returned instruction, valid when Ihit.
- Ihit  input  1  I-cache hit/return this cycle.
- validOut  output  1  output buffer holds a live instruction.
- PCOut  output  32  PC of buffered instruction.
- instrOut  output  32  buffered instruction; 0 (nop) when !validOut.
- PCPlus4Out  output  32  PCOut+4.
- BranchOut  output  1  buffered instruction is a control-transfer.

Behaviour:
- Definition: advance = en & Dhit. The buffer is consumed when advance & validOut.
- Reset (synchronous, clk edge with reset=1):
  - pc=RESET_PC, state=FETCH.
  - validOut=0; PCOut, instrOut, PCPlus4Out = 0; BranchOut=0.
  - icacheReq=0 in the reset cycle.
  - Reset asserted mid-miss or in DROP abandons everything; the first cycle after reset requests RESET_PC.
- States:
  - FETCH: icacheReq=1, icacheAddr=pc.
  - DROP: icacheReq=1, icacheAddr=dropPC, which is held stable until Ihit so an in-flight refill completes.
- Capture:
  - Condition: FETCH & Ihit & !redirect & (!validOut | advance).
  - Buffer <= {pc, icacheInstr, pc+4, predecode(icacheInstr)}; validOut=1; pc <= pc+4.
  - Latency: 1 cycle from Ihit to outputs.
  - Sustained hits with advance every cycle give 1 instr/cycle.
- Buffer full & !advance: Ihit is ignored, pc is held, the request stays asserted (the same address re-hits later).
- Consume without capture: validOut<=0, instrOut<=0.
- Redirect has the highest priority:
  - The buffer is flushed (validOut<=0, outputs zeroed) regardless of advance.
  - pc <= {redirectPC[31:2],2'b00}.
  - In FETCH with !Ihit (miss outstanding): dropPC<=pc, go to DROP.
  - In FETCH with Ihit the same cycle: the returned word is discarded, stay in FETCH.
  - In DROP: pc is updated to the newest redirectPC, stay in DROP.
- DROP & Ihit: the word is discarded, go to FETCH; the next request uses pc.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Predecode: BranchOut=1 when either condition holds:
  - opcode in {000001, 000010, 000011, 000100, 000101, 000110, 000111};
  - opcode=000000 with funct in {001000, 001001}.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs missCycles[31:0] and fetchCount[31:0], both saturating at 32'hFFFF_FFFF and cleared by reset.
  - missCycles increments each cycle icacheReq & !Ihit.
  - fetchCount increments on each capture.
- When undefined: the ports and logic are absent, and all other behaviour is identical.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {FETCH, DROP}.
  - MIPS opcode/funct constants for control transfers.
  - RESET_PC_DEFAULT.
- Sub-module branch_predecode (combinational, instr[31:0] -> isBranch) is natural; reused later by the BTB.

Test Plan:
- Reset then Ihit=1, en=Dhit=1 every cycle -> addresses 0,4,8,C on consecutive cycles; PCOut follows one cycle later; PCPlus4Out=PCOut+4.
- Ihit=1 with buffer full and en=0 for 3 cycles -> pc held at 8, buffer unchanged; en=1 -> buffer becomes instr@8, pc=C.
- Miss at pc=10 (Ihit=0), redirect to 32'h0000_0203 -> icacheAddr stays 10 until Ihit, that word is discarded; next request is 32'h0000_0200; validOut=0 throughout.
- Redirect to 32'h0000_0100 same cycle as Ihit -> word dropped, buffer flushed, next address 100.
- Instr 32'h1000_0003 (beq) -> BranchOut=1; 32'h03E0_0008 (jr) -> 1; 32'h2108_0001 (addi) -> 0.
- pc=32'hFFFF_FFFC with hit -> next pc 0; reset asserted during DROP -> next request is RESET_PC, validOut=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and MIPS control-transfer encodings for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic {FETCH, DROP} fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

endpackage

// File: rtl/branch_predecode.sv
// Combinational predecode: flags any MIPS branch, jump or register jump.
module branch_predecode
  import fetch_pkg::*;
(
  input  logic [31:0] instr,
  output logic        isBranch
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    isBranch = 1'b0;
    case (opcode)
      OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: isBranch = 1'b1;
      OP_SPECIAL: isBranch = (funct == FN_JR) || (funct == FN_JALR);
      default:    isBranch = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, I-cache request, one-entry output buffer.
// Optional perf counters (missCycles, fetchCount) under FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        Dhit,
  input  logic        redirect,
  input  logic [31:0] redirectPC,
  output logic        icacheReq,
  output logic [31:0] icacheAddr,
  input  logic [31:0] icacheInstr,
  input  logic        Ihit,
  output logic        validOut,
  output logic [31:0] PCOut,
  output logic [31:0] instrOut,
  output logic [31:0] PCPlus4Out,
  output logic        BranchOut
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] missCycles,
  output logic [31:0] fetchCount
`endif
);

  fetch_state_t state, state_next;
  logic [31:0]  pc;
  logic [31:0]  drop_pc;
  logic [31:0]  pc_plus4;
  logic         advance;
  logic         capture;
  logic         fetched_branch;
  logic         unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirectPC[1:0];

  branch_predecode u_predecode (
    .instr    (icacheInstr),
    .isBranch (fetched_branch)
  );

  assign pc_plus4   = pc + 32'd4;
  assign advance    = en & Dhit;
  assign capture    = (state == FETCH) & Ihit & ~redirect & (~validOut | advance);
  assign icacheReq  = ~reset;
  assign icacheAddr = (state == DROP) ? drop_pc : pc;

  // A miss caught by a redirect must still be allowed to finish at its old address.
  always_comb begin
    state_next = state;
    case (state)
      FETCH: if (redirect && !Ihit) state_next = DROP;
      DROP:  if (!redirect && Ihit) state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      drop_pc    <= 32'd0;
      validOut   <= 1'b0;
      PCOut      <= 32'd0;
      instrOut   <= 32'd0;
      PCPlus4Out <= 32'd0;
      BranchOut  <= 1'b0;
    end else begin
      state <= state_next;
      if (redirect) begin
        pc         <= {redirectPC[31:2], 2'b00};
        validOut   <= 1'b0;
        PCOut      <= 32'd0;
        instrOut   <= 32'd0;
        PCPlus4Out <= 32'd0;
        BranchOut  <= 1'b0;
        if (state == FETCH && !Ihit) drop_pc <= pc;
      end else if (capture) begin
        pc         <= pc_plus4;
        validOut   <= 1'b1;
        PCOut      <= pc;
        instrOut   <= icacheInstr;
        PCPlus4Out <= pc_plus4;
        BranchOut  <= fetched_branch;
      end else if (advance && validOut) begin
        validOut  <= 1'b0;
        instrOut  <= 32'd0;
        BranchOut <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      missCycles <= 32'd0;
      fetchCount <= 32'd0;
    end else begin
      if (icacheReq && !Ihit && missCycles != 32'hFFFF_FFFF) missCycles <= missCycles + 32'd1;
      if (capture && fetchCount != 32'hFFFF_FFFF) fetchCount <= fetchCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: predecode vector table plus directed stall/redirect/wrap/reset sequences.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, en, Dhit, redirect, Ihit;
  logic [31:0] redirectPC, icacheInstr, icacheAddr;
  logic        icacheReq, validOut, BranchOut;
  logic [31:0] PCOut, instrOut, PCPlus4Out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic        br;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        br;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[12];
  logic [31:0] exp_pc;
  logic [31:0] last_instr;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .Dhit        (Dhit),
    .redirect    (redirect),
    .redirectPC  (redirectPC),
    .icacheReq   (icacheReq),
    .icacheAddr  (icacheAddr),
    .icacheInstr (icacheInstr),
    .Ihit        (Ihit),
    .validOut    (validOut),
    .PCOut       (PCOut),
    .instrOut    (instrOut),
    .PCPlus4Out  (PCPlus4Out),
    .BranchOut   (BranchOut)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a hitting fetch at the expected pc and record the buffer contents it should produce.
  task automatic push_capture(input logic [31:0] instr, input logic br);
    exp_t e;
    chk("fetch_addr", icacheAddr, exp_pc);
    icacheInstr = instr;
    Ihit = 1'b1;
    e.pc = exp_pc; e.instr = instr; e.pc4 = exp_pc + 32'd4; e.br = br;
    sb.push_back(e);
    exp_pc = exp_pc + 32'd4;
    last_instr = instr;
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("validOut", {31'd0, validOut}, 32'd1);
      chk("PCOut", PCOut, e.pc);
      chk("instrOut", instrOut, e.instr);
      chk("PCPlus4Out", PCPlus4Out, e.pc4);
      chk("BranchOut", {31'd0, BranchOut}, {31'd0, e.br});
    end
  endtask

  function automatic logic [31:0] plain_instr(input logic [31:0] a);
    return 32'h2000_0000 | {16'd0, a[15:0]};
  endfunction

  initial begin
    vecs[0]  = '{32'h1000_0003, 1'b1};  // beq
    vecs[1]  = '{32'h03E0_0008, 1'b1};  // jr
    vecs[2]  = '{32'h2108_0001, 1'b0};  // addi
    vecs[3]  = '{32'h0000_F809, 1'b1};  // jalr
    vecs[4]  = '{32'h0800_0010, 1'b1};  // j
    vecs[5]  = '{32'h0C00_0020, 1'b1};  // jal
    vecs[6]  = '{32'h0401_0002, 1'b1};  // regimm
    vecs[7]  = '{32'h1422_0004, 1'b1};  // bne
    vecs[8]  = '{32'h1840_0001, 1'b1};  // blez
    vecs[9]  = '{32'h1C60_0001, 1'b1};  // bgtz
    vecs[10] = '{32'h0000_000A, 1'b0};  // special, funct not jr/jalr
    vecs[11] = '{32'h8C41_0000, 1'b0};  // lw

    reset = 1'b1; en = 1'b1; Dhit = 1'b1; redirect = 1'b0; Ihit = 1'b0;
    redirectPC = 32'd0; icacheInstr = 32'd0; exp_pc = 32'd0; last_instr = 32'd0;

    tick();
    chk("reset_req", {31'd0, icacheReq}, 32'd0);
    chk("reset_valid", {31'd0, validOut}, 32'd0);
    chk("reset_pcout", PCOut, 32'd0);
    chk("reset_instr", instrOut, 32'd0);
    chk("reset_pc4", PCPlus4Out, 32'd0);
    chk("reset_branch", {31'd0, BranchOut}, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_reset_req", {31'd0, icacheReq}, 32'd1);

    // Back-to-back hits with the decode register advancing every cycle.
    for (int i = 0; i < 12; i++) begin
      push_capture(vecs[i].instr, vecs[i].br);
      tick();
      pop_compare();
    end

    // Buffer full and stalled: hits ignored, pc held.
    en = 1'b0; icacheInstr = 32'hDEAD_BEEF; Ihit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr", icacheAddr, exp_pc);
      chk("stall_instr", instrOut, last_instr);
      chk("stall_pcout", PCOut, exp_pc - 32'd4);
    end
    en = 1'b1; Dhit = 1'b0;
    tick();
    chk("dmiss_addr", icacheAddr, exp_pc);
    chk("dmiss_instr", instrOut, last_instr);
    Dhit = 1'b1;
    push_capture(plain_instr(exp_pc), 1'b0);
    tick();
    pop_compare();

    // Consume without capture.
    Ihit = 1'b0;
    tick();
    chk("consume_valid", {31'd0, validOut}, 32'd0);
    chk("consume_instr", instrOut, 32'd0);
    chk("consume_addr", icacheAddr, exp_pc);

    // Redirect during a miss: old address held until its refill lands, then discarded.
    redirect = 1'b1; redirectPC = 32'h0000_0203;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drop_addr", icacheAddr, exp_pc);
      chk("drop_valid", {31'd0, validOut}, 32'd0);
      if (i < 2) tick();
    end
    Ihit = 1'b1; icacheInstr = 32'h1234_5678;
    tick();
    chk("drop_done_valid", {31'd0, validOut}, 32'd0);
    exp_pc = 32'h0000_0200;
    push_capture(plain_instr(exp_pc), 1'b0);
    tick();
    pop_compare();

    // Redirect coinciding with a hit while the buffer is full and stalled.
    en = 1'b0; redirect = 1'b1; redirectPC = 32'h0000_0100; icacheInstr = 32'h1000_0001;
    tick();
    redirect = 1'b0; en = 1'b1;
    chk("redir_hit_valid", {31'd0, validOut}, 32'd0);
    chk("redir_hit_instr", instrOut, 32'd0);
    chk("redir_hit_pcout", PCOut, 32'd0);
    exp_pc = 32'h0000_0100;
    push_capture(plain_instr(exp_pc), 1'b0);
    tick();
    pop_compare();

    // pc wraps past the top of the address space.
    redirect = 1'b1; redirectPC = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    exp_pc = 32'hFFFF_FFFC;
    push_capture(32'h1000_0003, 1'b1);
    tick();
    pop_compare();
    chk("wrap_addr", icacheAddr, 32'd0);
    push_capture(plain_instr(exp_pc), 1'b0);
    tick();
    pop_compare();

    // Reset while parked in DROP.
    Ihit = 1'b0; redirect = 1'b1; redirectPC = 32'h0000_0400;
    tick();
    redirect = 1'b0;
    chk("pre_reset_drop_addr", icacheAddr, 32'h0000_0004);
    reset = 1'b1;
    tick();
    chk("drop_reset_req", {31'd0, icacheReq}, 32'd0);
    chk("drop_reset_valid", {31'd0, validOut}, 32'd0);
    reset = 1'b0;
    #1;
    chk("drop_reset_addr", icacheAddr, 32'd0);
    exp_pc = 32'd0;
    push_capture(plain_instr(exp_pc), 1'b0);
    tick();
    pop_compare();
    chk("final_addr", icacheAddr, 32'h0000_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
